// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage: a loader fills the array,
// then byte-addressed fetches are answered one cycle later with error flagging.
module imem_responder #(
  parameter int N      = 64,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          req_valid,
  input  logic [N-1:0]  req_addr,
  input  logic          req_flush,
  output logic          req_ready,
  output logic          resp_valid,
  output logic [31:0]   resp_instr,
  output logic          resp_err
);

  localparam logic ST_LOAD  = 1'b0;
  localparam logic ST_SERVE = 1'b1;

  logic         state;
  logic [AW:0]  wr_ptr;
  logic [AW:0]  count;
  logic [31:0]  mem [DEPTH];

  logic [N-3:0] word;
  logic [N-3:0] count_ext;
  logic         load_fire;
  logic         req_fire;
  logic         misaligned;
  logic         out_of_range;

  assign load_ready   = (state == ST_LOAD);
  assign req_ready    = (state == ST_SERVE);
  assign load_fire    = load_valid && load_ready;
  assign req_fire     = req_valid && req_ready && !req_flush;

  // The range check uses the whole word index so huge PCs never alias low words.
  assign word         = req_addr[N-1:2];
  assign count_ext    = (N-2)'(count);
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = (word >= count_ext);

  always_ff @(posedge clk) begin
    if (load_fire)
      mem[wr_ptr[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_LOAD;
      wr_ptr     <= '0;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_instr <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (load_fire) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        count  <= count + (AW+1)'(1);
        // Filling the last slot forces the switch even without load_last.
        if (load_last || wr_ptr == (AW+1)'(DEPTH-1))
          state <= ST_SERVE;
      end

      resp_valid <= req_fire;
      if (req_fire) begin
        if (misaligned || out_of_range) begin
          resp_instr <= '0;
          resp_err   <= 1'b1;
        end else begin
          resp_instr <= mem[word[AW-1:0]];
          resp_err   <= 1'b0;
        end
      end else begin
        resp_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder: a word-array model predicts
// every response, plus directed sequences pinned to hand-computed values.
module tb_imem_responder;

  localparam int N     = 64;
  localparam int DEPTH = 64;

  logic          clk;
  logic          reset;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic          req_valid;
  logic [N-1:0]  req_addr;
  logic          req_flush;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_instr;
  logic          resp_err;

  int errors = 0;
  int checks = 0;

  imem_responder #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_flush  (req_flush),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_instr (resp_instr),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: loaded words, how many, and whether serving has begun.
  logic [31:0]   m_mem [DEPTH];
  int            m_count;
  bit            m_serving;
  bit            m_started = 0;
  bit            exp_valid;
  bit            exp_err;
  logic [31:0]   exp_instr;

  always @(posedge clk) begin
    if (!reset) begin
      m_started = 1;
      m_serving = 0;
      m_count   = 0;
      exp_valid = 0;
      exp_err   = 0;
      exp_instr = '0;
    end else if (m_started) begin
      if (!m_serving) begin
        exp_valid = 0;
        exp_err   = 0;
        if (load_valid) begin
          m_mem[m_count] = load_data;
          m_count = m_count + 1;
          if (load_last || m_count == DEPTH) m_serving = 1;
        end
      end else if (req_valid && !req_flush) begin
        exp_valid = 1;
        exp_err   = (req_addr % 4 != 0) || ((req_addr >> 2) >= 64'(m_count));
        exp_instr = exp_err ? 32'h0 : m_mem[int'(req_addr >> 2)];
      end else begin
        exp_valid = 0;
        exp_err   = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, the outputs must agree with the model.
  always @(negedge clk) begin
    if (m_started) begin
      checkOutput("load_ready", 64'(load_ready), 64'(!m_serving));
      checkOutput("req_ready", 64'(req_ready), 64'(m_serving));
      checkOutput("resp_valid", 64'(resp_valid), 64'(exp_valid));
      checkOutput("resp_err", 64'(resp_err), 64'(exp_err));
      if (exp_valid) checkOutput("resp_instr", 64'(resp_instr), 64'(exp_instr));
    end
  end

  task automatic applyStimulus(input logic lv, input logic [31:0] ld, input logic ll,
                               input logic rv, input logic [N-1:0] ra, input logic rf);
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    req_valid  = rv;
    req_addr   = ra;
    req_flush  = rf;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 32'h0, 0, 0, '0, 0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    idle();
    idle();
    reset = 1'b1;
  endtask

  task automatic randomAddr(input int cnt, output logic [N-1:0] a);
    case ($urandom_range(0, 4))
      0, 1:    a = 64'($urandom_range(0, cnt + 1)) << 2;
      2:       a = (64'($urandom_range(0, cnt)) << 2) | 64'($urandom_range(1, 3));
      3:       a = {$urandom, $urandom};
      default: a = 64'($urandom_range(0, 300));
    endcase
  endtask

  logic [31:0] prog [4];
  logic [31:0] big  [DEPTH];
  logic [N-1:0] addr;

  initial begin
    prog[0] = 32'h8B020020;
    prog[1] = 32'hCB030041;
    prog[2] = 32'hF8000002;
    prog[3] = 32'hB4000040;
    reset = 1'b0;
    load_valid = 0; load_data = '0; load_last = 0;
    req_valid = 0; req_addr = '0; req_flush = 0;
    @(posedge clk);
    #1;
    doReset();

    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_resp_instr", 64'(resp_instr), 64'd0);
    checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
    checkOutput("rst_load_ready", 64'(load_ready), 64'd1);

    // Four-word program, then in-order back-to-back fetches.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, prog[i], i == 3, 0, '0, 0);
      checkOutput("load_ready_after_word", 64'(load_ready), (i == 3) ? 64'd0 : 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 32'h0, 0, 1, 64'(i * 4), 0);
      checkOutput("b2b_valid", 64'(resp_valid), 64'd1);
      checkOutput("b2b_instr", 64'(resp_instr), 64'(prog[i]));
    end
    applyStimulus(0, 32'h0, 0, 1, 64'd16, 0);
    checkOutput("oor16_err", 64'(resp_err), 64'd1);
    checkOutput("oor16_instr", 64'(resp_instr), 64'd0);
    applyStimulus(0, 32'h0, 0, 1, 64'h8000000000000000, 0);
    checkOutput("nowrap_err", 64'(resp_err), 64'd1);
    applyStimulus(0, 32'h0, 0, 1, 64'd6, 0);
    checkOutput("misalign_err", 64'(resp_err), 64'd1);
    checkOutput("misalign_instr", 64'(resp_instr), 64'd0);
    applyStimulus(0, 32'h0, 0, 1, 64'd4, 1);
    checkOutput("flush_no_resp", 64'(resp_valid), 64'd0);

    // Reset while a response is in flight.
    applyStimulus(0, 32'h0, 0, 1, 64'd0, 0);
    checkOutput("pending_valid", 64'(resp_valid), 64'd1);
    reset = 1'b0;
    idle();
    reset = 1'b1;
    checkOutput("abort_valid", 64'(resp_valid), 64'd0);
    checkOutput("abort_load_ready", 64'(load_ready), 64'd1);
    applyStimulus(0, 32'h0, 0, 1, 64'd0, 0);
    checkOutput("reload_req_ready", 64'(req_ready), 64'd0);
    checkOutput("reload_no_resp", 64'(resp_valid), 64'd0);

    // Gapped load with requests sprinkled in; only handshaken words count.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, $urandom, 1, 1, 64'(i * 4), 0);
      applyStimulus(1, $urandom, i == 7, $urandom_range(0, 1), 64'(i * 4), 0);
    end
    for (int i = 0; i < 10; i++) applyStimulus(0, 32'h0, 0, 1, 64'(i * 4), 0);

    // Full load with no load_last: auto-switch after the last slot.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      big[i] = $urandom;
      applyStimulus(1, big[i], 0, 0, '0, 0);
    end
    checkOutput("full_load_ready", 64'(load_ready), 64'd0);
    applyStimulus(1, 32'hDEADBEEF, 1, 1, 64'd252, 0);
    checkOutput("word63_instr", 64'(resp_instr), 64'(big[DEPTH-1]));
    checkOutput("word63_err", 64'(resp_err), 64'd0);
    applyStimulus(0, 32'h0, 0, 1, 64'd256, 0);
    checkOutput("addr256_err", 64'(resp_err), 64'd1);

    // Random rounds of load and serve traffic.
    for (int r = 0; r < 20; r++) begin
      int target;
      target = $urandom_range(1, DEPTH + 4);
      doReset();
      for (int c = 0; c < 200 && !m_serving; c++) begin
        randomAddr(8, addr);
        applyStimulus($urandom_range(0, 3) != 0, $urandom,
                      (m_count + 1 >= target) && ($urandom_range(0, 1) == 1),
                      $urandom_range(0, 1), addr, $urandom_range(0, 1));
      end
      for (int c = 0; c < 80; c++) begin
        randomAddr(m_count, addr);
        applyStimulus($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                      $urandom_range(0, 3) != 0, addr, $urandom_range(0, 4) == 0);
      end
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
